reg_file_param: RTL
===================

Name: reg_file_param

Overview:
Parametrised successor to the CPU's 8x8 register file. It provides DEPTH registers of DATA_WIDTH bits, with two combinational read ports and one clocked write port. Adds four features: optional hardwired zero register, write-to-read bypass, a write-completion pulse, and a sequenced CLEAR sweep FSM that zeroes one entry per cycle. Sits between the control unit/ALU writeback path and the operand fetch of the datapath; stalls on data-memory BUSYWAIT.

Parameters:
DATA_WIDTH, 8, bits per register
ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH entries
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports:
CLK  in  1  clock, all state updates on posedge
RESET_N  in  1  asynchronous active-low reset
IN  in  DATA_WIDTH  write data
INADDRESS  in  ADDR_WIDTH  write address
WRITE  in  1  write request
BUSYWAIT  in  1  memory stall; blocks writes while high
OUT1ADDRESS  in  ADDR_WIDTH  read port 1 address
OUT2ADDRESS  in  ADDR_WIDTH  read port 2 address
OUT1  out  DATA_WIDTH  read port 1 data
OUT2  out  DATA_WIDTH  read port 2 data
CLEAR  in  1  start clear sweep (sampled on posedge)
CLEAR_BUSY  out  1  high while sweep in progress
WRITE_DONE  out  1  one-cycle pulse after a committed write

Behaviour:
- Reset (RESET_N low, asynchronous, no clock needed):
  - all entries = 0; FSM = IDLE; sweep index = 0; CLEAR_BUSY = 0; WRITE_DONE = 0.
  - Deassertion is sampled on the next posedge. Reset during a sweep aborts it immediately.
- Write enable: we = WRITE & ~BUSYWAIT & (state == IDLE).
- Write: at posedge with we, entry[INADDRESS] <= IN.
  - Exception: ZERO_REG=1 and INADDRESS=0 → no update.
  - WRITE_DONE registered: high for exactly the cycle after the committing edge, including a ZERO_REG discard. Otherwise 0.
- Reads: combinational, OUTx = entry[OUTxADDRESS].
  - ZERO_REG=1 and address 0 → OUTx = 0.
  - BYPASS=1, we=1, INADDRESS == OUTxADDRESS (and not the zero register) → OUTx = IN in the same cycle.
  - BYPASS=0 → the new value is visible only after the edge.
- FSM, two states:
  - IDLE → SWEEP when CLEAR=1 at posedge. Index set to 0 on entry. Per the write-enable rule, a write requested on the same edge still commits.
  - SWEEP: each posedge writes entry[index] <= 0 and increments index. After the edge that clears entry DEPTH-1, index wraps to 0 and the FSM returns to IDLE. Sweep length is exactly DEPTH cycles.
  - CLEAR_BUSY = (state == SWEEP), registered.
  - CLEAR while in SWEEP is ignored (no restart).
  - BUSYWAIT does not pause the sweep.
- Writes during SWEEP are dropped: no update, no WRITE_DONE. The writer must watch CLEAR_BUSY and retry.
- No bypass during SWEEP, because we=0.
- Reads during SWEEP return current contents: already-cleared entries read 0, uncleared entries keep their old values.
- No X on outputs after reset for any address.

Test Plan:
- Reset: write 8'hA5 to all 8 entries; pulse RESET_N low mid-cycle → all reads return 0 before the next posedge; CLEAR_BUSY=0; WRITE_DONE=0.
- Write/read/bypass: WRITE=1, INADDRESS=3, IN=8'h5C, OUT1ADDRESS=3 → OUT1=8'h5C in the same cycle (BYPASS=1); WRITE_DONE=1 the next cycle. Repeat with BYPASS=0 → OUT1 = old value until after the edge.
- BUSYWAIT stall: WRITE=1, BUSYWAIT=1 for 3 cycles, IN=8'h11, addr 2 → entry 2 unchanged, no WRITE_DONE. Release BUSYWAIT → committed, WRITE_DONE pulses once.
- Clear sweep: fill entries with 1..8; assert CLEAR one cycle → CLEAR_BUSY high for exactly 8 cycles; entry k reads 0 after sweep cycle k, uncleared entries still hold their values; a write issued mid-sweep is dropped; second CLEAR mid-sweep does not extend the sweep.
- Reset mid-sweep: RESET_N low at sweep cycle 3 → CLEAR_BUSY=0 and all entries 0 immediately; a subsequent write succeeds on the first edge after release.
- ZERO_REG=1, DATA_WIDTH=16, ADDR_WIDTH=4: write 16'hBEEF to addr 0 → reads 0 and WRITE_DONE pulses. Write to addr 15 → reads 16'hBEEF; sweep lasts 16 cycles.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one clocked write port,
// optional hardwired zero entry, write-to-read bypass, write-done pulse and clear sweep.
module reg_file_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic                  BUSYWAIT,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  input  logic                  CLEAR,
  output logic                  CLEAR_BUSY,
  output logic                  WRITE_DONE
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_next_idx;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_clear_busy;
  logic                  r_write_done;
  logic                  w_we;
  logic                  w_wr_zero;

  assign w_we      = WRITE & ~BUSYWAIT & (r_state == ST_IDLE);
  assign w_wr_zero = (ZERO_REG != 0) && (INADDRESS == '0);

  // State and sweep index registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  // Next-state logic; the sweep always runs DEPTH cycles and ignores CLEAR once started
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (CLEAR) begin
          w_next_state = ST_SWEEP;
          w_next_idx   = '0;
        end
      end
      ST_SWEEP: begin
        w_next_idx = r_idx + ADDR_WIDTH'(1);
        if (r_idx == LAST_IDX) begin
          w_next_state = ST_IDLE;
          w_next_idx   = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_idx   = '0;
      end
    endcase
  end

  // Storage: sweep clear takes the port while busy, otherwise normal write
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == ST_SWEEP) begin
      r_mem[r_idx] <= '0;
    end else if (w_we && !w_wr_zero) begin
      r_mem[INADDRESS] <= IN;
    end
  end

  // Status flags; a discarded zero-register write still counts as committed
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_clear_busy <= 1'b0;
      r_write_done <= 1'b0;
    end else begin
      r_clear_busy <= (w_next_state == ST_SWEEP);
      r_write_done <= w_we;
    end
  end

  assign CLEAR_BUSY = r_clear_busy;
  assign WRITE_DONE = r_write_done;

  // Read port 1
  always_comb begin
    OUT1 = r_mem[OUT1ADDRESS];
    if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
      OUT1 = '0;
    end else if ((BYPASS != 0) && w_we && (INADDRESS == OUT1ADDRESS)) begin
      OUT1 = IN;
    end
  end

  // Read port 2
  always_comb begin
    OUT2 = r_mem[OUT2ADDRESS];
    if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
      OUT2 = '0;
    end else if ((BYPASS != 0) && w_we && (INADDRESS == OUT2ADDRESS)) begin
      OUT2 = IN;
    end
  end

endmodule
